// File: rtl/mcd_pkg.sv
// Shared definitions for the mcd median-of-three selector.
package mcd_pkg;

  // Default sample width in bits (unsigned samples).
  localparam int MCD_WIDTH = 8;

  // One sample at the default width.
  typedef logic [MCD_WIDTH-1:0] mcd_sample_t;

endpackage : mcd_pkg

// File: rtl/mcd_median3_core.sv
// Combinational median-of-three select driven by precomputed compare flags.
// g01 = a0>a1, g02 = a0>a2, g12 = a1>a2 (all unsigned).
module mcd_median3_core
  import mcd_pkg::*;
#(
  parameter int WIDTH = MCD_WIDTH
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic             g01,
  input  logic             g02,
  input  logic             g12,
  output logic [WIDTH-1:0] med_o
);

  // a0 is the median when it beats exactly one of the other two; otherwise
  // a1 is the median when it sits between a0 and a2 (flags agree), else a2.
  // Ties fall out naturally: an equal pair never sets its flag, which steers
  // selection onto one member of the repeated value.
  always_comb begin
    med_o = a2;
    if ((g01 ^ g02) == 1'b1) begin
      med_o = a0;
    end else if (g01 == g12) begin
      med_o = a1;
    end else begin
      med_o = a2;
    end
  end

endmodule : mcd_median3_core

// File: rtl/mcd.sv
// Two-stage registered median-of-three selector, one result per clock.
// Stage 1 captures the samples and their pairwise compare flags; stage 2
// selects the median and registers it onto R.
module mcd
  import mcd_pkg::*;
#(
  parameter int WIDTH = MCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] R,
  output logic             out_valid
);

  // Stage-1 state
  logic [WIDTH-1:0] s1_a0_q, s1_a0_d;
  logic [WIDTH-1:0] s1_a1_q, s1_a1_d;
  logic [WIDTH-1:0] s1_a2_q, s1_a2_d;
  logic             s1_g01_q, s1_g01_d;
  logic             s1_g02_q, s1_g02_d;
  logic             s1_g12_q, s1_g12_d;
  logic             v1_q, v1_d;

  // Stage-2 state
  logic [WIDTH-1:0] r_q, r_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] med_s;

  // Stage-1 next state: load samples and flags on valid, otherwise hold data.
  always_comb begin
    s1_a0_d  = s1_a0_q;
    s1_a1_d  = s1_a1_q;
    s1_a2_d  = s1_a2_q;
    s1_g01_d = s1_g01_q;
    s1_g02_d = s1_g02_q;
    s1_g12_d = s1_g12_q;
    v1_d     = 1'b0;
    if (in_valid == 1'b1) begin
      s1_a0_d  = a0;
      s1_a1_d  = a1;
      s1_a2_d  = a2;
      s1_g01_d = (a0 > a1);
      s1_g02_d = (a0 > a2);
      s1_g12_d = (a1 > a2);
      v1_d     = 1'b1;
    end else begin
      v1_d     = 1'b0;
    end
  end

  // Stage-1 registers; reset discards any captured triple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a0_q  <= {WIDTH{1'b0}};
      s1_a1_q  <= {WIDTH{1'b0}};
      s1_a2_q  <= {WIDTH{1'b0}};
      s1_g01_q <= 1'b0;
      s1_g02_q <= 1'b0;
      s1_g12_q <= 1'b0;
      v1_q     <= 1'b0;
    end else begin
      s1_a0_q  <= s1_a0_d;
      s1_a1_q  <= s1_a1_d;
      s1_a2_q  <= s1_a2_d;
      s1_g01_q <= s1_g01_d;
      s1_g02_q <= s1_g02_d;
      s1_g12_q <= s1_g12_d;
      v1_q     <= v1_d;
    end
  end

  mcd_median3_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a0    (s1_a0_q),
    .a1    (s1_a1_q),
    .a2    (s1_a2_q),
    .g01   (s1_g01_q),
    .g02   (s1_g02_q),
    .g12   (s1_g12_q),
    .med_o (med_s)
  );

  // Stage-2 next state: publish the median when stage 1 was valid, else hold R.
  always_comb begin
    r_d         = r_q;
    out_valid_d = 1'b0;
    if (v1_q == 1'b1) begin
      r_d         = med_s;
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign R         = r_q;
  assign out_valid = out_valid_q;

endmodule : mcd

// File: tb/tb_mcd.sv
// Directed self-checking bench for mcd with a scoreboard of expected medians.
module tb_mcd;
  import mcd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  mcd_sample_t a0, a1, a2;
  mcd_sample_t R;
  logic        out_valid;

  mcd_sample_t exp_q[$];
  logic [1:0]  vpipe;
  mcd_sample_t last_r;
  int          n_assert;
  int          n_fail;

  mcd #(.WIDTH(MCD_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .R         (R),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference median by "lies between the other two" test, independent of the flag scheme.
  function automatic mcd_sample_t med3(input mcd_sample_t x, input mcd_sample_t y, input mcd_sample_t z);
    if ((x >= y && x <= z) || (x <= y && x >= z)) return x;
    else if ((y >= x && y <= z) || (y <= x && y >= z)) return y;
    else return z;
  endfunction

  task automatic check(input string tag, input mcd_sample_t obs, input mcd_sample_t expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge: check outputs due now, drive the next input, advance one cycle.
  task automatic step(input logic v, input mcd_sample_t x0, input mcd_sample_t x1, input mcd_sample_t x2);
    mcd_sample_t e;
    check("out_valid", {7'd0, out_valid}, {7'd0, vpipe[1]});
    if (vpipe[1]) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 8'd1, 8'd0);
      end else begin
        e = exp_q.pop_front();
        check("R", R, e);
        last_r = e;
      end
    end else begin
      check("R_hold", R, last_r);
    end
    in_valid = v;
    a0 = x0;
    a1 = x1;
    a2 = x2;
    if (v) exp_q.push_back(med3(x0, x1, x2));
    vpipe = {vpipe[0], v};
    @(negedge clk);
  endtask

  task automatic flush();
    step(1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    mcd_sample_t p [3];
    n_assert = 0;
    n_fail   = 0;
    vpipe    = 2'b00;
    last_r   = 8'd0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a0 = 8'd0; a1 = 8'd0; a2 = 8'd0;

    // Reset held with toggling inputs: outputs stay cleared.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a0 = 8'($urandom_range(255)); a1 = 8'($urandom_range(255)); a2 = 8'($urandom_range(255));
      @(negedge clk);
      check("reset_R", R, 8'd0);
      check("reset_out_valid", {7'd0, out_valid}, 8'd0);
    end
    rst_n = 1'b1;

    // First triple straight after reset release.
    step(1'b1, 8'd1, 8'd2, 8'd4);
    flush();

    // One-hot sweep, 512 back-to-back triples.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 8; k++)
          step(1'b1, 8'(1 << i), 8'(1 << j), 8'(1 << k));
    flush();

    // Ties and extremes.
    step(1'b1, 8'd0,   8'd0,   8'd0);
    step(1'b1, 8'd255, 8'd255, 8'd0);
    step(1'b1, 8'd255, 8'd0,   8'd0);
    step(1'b1, 8'd128, 8'd128, 8'd128);
    step(1'b1, 8'd1,   8'd1,   8'd128);
    step(1'b1, 8'd0,   8'd255, 8'd255);
    flush();

    // All six permutations of (10,200,50).
    p[0] = 8'd10; p[1] = 8'd200; p[2] = 8'd50;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 3; k++)
          if (i != j && j != k && i != k) step(1'b1, p[i], p[j], p[k]);
    flush();

    // Gaps: valid pattern 1,0,1,1,0; R must hold through the idle slots.
    step(1'b1, 8'd30, 8'd20, 8'd99);
    step(1'b0, 8'd7,  8'd8,  8'd9);
    step(1'b1, 8'd77, 8'd66, 8'd55);
    step(1'b1, 8'd3,  8'd250, 8'd100);
    step(1'b0, 8'd1,  8'd2,  8'd3);
    flush();

    // Mid-stream reset: nonzero R on output, one triple in stage 1, one on the inputs.
    step(1'b1, 8'd40, 8'd90, 8'd60);
    step(1'b1, 8'd11, 8'd12, 8'd13);
    step(1'b1, 8'd21, 8'd22, 8'd23);
    in_valid = 1'b1;
    a0 = 8'd31; a1 = 8'd32; a2 = 8'd33;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_R", R, 8'd0);
    check("midreset_out_valid", {7'd0, out_valid}, 8'd0);
    exp_q.delete();
    vpipe  = 2'b00;
    last_r = 8'd0;
    @(negedge clk);
    check("midreset_hold_R", R, 8'd0);
    check("midreset_hold_out_valid", {7'd0, out_valid}, 8'd0);
    rst_n = 1'b1;
    flush();
    flush();

    // Short post-reset burst to confirm the pipeline restarts cleanly.
    step(1'b1, 8'd5, 8'd200, 8'd17);
    step(1'b1, 8'd128, 8'd1, 8'd16);
    flush();

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mcd
